// File: rtl/ram_cmd_pkg.sv
// Shared encodings for the SPI-fed RAM command controller: opcodes, FSM states, defaults.
// Pure declarations; no timing or flow-control behaviour of its own.
package ram_cmd_pkg;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_TX   = 1'b1;

    localparam int TX_HOLD_DEFAULT = 9;

    // Even parity: stored bit makes the total count of ones across {p, data} even.
    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port word store: one access per cycle, synchronous write, registered read.
// Read data appears one cycle after re_i and holds until the next read; no backpressure.
module ram_sp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    // Array is deliberately left out of reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_cmd_ctrl.sv
// SPI command decoder driving a single-port RAM; optional RAM_PARITY_EN adds per-word even parity.
// Read data valid 1 cycle after RD_DATA and held TX_HOLD cycles; RD_DATA during TX is dropped.
module ram_cmd_ctrl
    import ram_cmd_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int TX_HOLD   = TX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       par_err
);

    localparam int              RAM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int              CW        = $clog2(TX_HOLD + 1);
    localparam logic [8:0]      DEPTH_LIM = 9'(MEM_DEPTH);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(TX_HOLD);
    localparam logic [CW-1:0]   CNT_FIRST = CW'(1);

`ifdef RAM_PARITY_EN
    localparam int DW = 9;
`else
    localparam int DW = 8;
`endif

    logic [1:0]    op;
    logic [7:0]    pl;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    rd_addr_q, rd_addr_d;
    logic          oob_q, oob_d;

    logic          wr_in_rng, rd_in_rng;
    logic          rd_go;
    logic          ram_we, ram_re;
    logic [7:0]    ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    assign op = din[9:8];
    assign pl = din[7:0];

    assign wr_in_rng = {1'b0, wr_addr_q} < DEPTH_LIM;
    assign rd_in_rng = {1'b0, rd_addr_q} < DEPTH_LIM;

    assign rd_go    = rx_valid && (op == RD_DATA) && (state_q == ST_IDLE);
    assign ram_we   = rx_valid && (op == WR_DATA) && wr_in_rng;
    assign ram_re   = rd_go && rd_in_rng;
    // Commands are one per cycle, so a write and a read never compete for the port.
    assign ram_addr = ram_we ? wr_addr_q : rd_addr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        oob_d     = oob_q;

        if (rx_valid && (op == WR_ADDR)) begin
            wr_addr_d = pl;
        end
        if (rx_valid && (op == RD_ADDR)) begin
            rd_addr_d = pl;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_go) begin
                    state_d = ST_TX;
                    cnt_d   = CNT_FIRST;
                    oob_d   = !rd_in_rng;
                end
            end
            ST_TX: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            oob_q     <= oob_d;
        end
    end

    ram_sp #(
        .DEPTH (MEM_DEPTH),
        .AW    (RAM_AW),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr[RAM_AW-1:0]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign tx_valid = (state_q == ST_TX);
    // RAM read register only reloads on an accepted read, so dout stays stable through TX.
    assign dout     = (tx_valid && !oob_q) ? ram_rdata[7:0] : 8'h00;

`ifdef RAM_PARITY_EN
    assign ram_wdata = {even_par(pl), pl};
    assign par_err   = tx_valid && (cnt_q == CNT_FIRST) && !oob_q && (^ram_rdata);
`else
    assign ram_wdata = pl;
    assign par_err   = 1'b0;
`endif

endmodule
